// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory among NUM_REQ requesters.
// One transaction in flight at a time; all outputs registered.
module memory_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                          memory_clk,
  input  logic                          memory_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic                          mem_vld_out,
  input  logic [DATA_WIDTH-1:0]         mem_data_out,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(RD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;
  state_t state, next_state;

  logic [PW-1:0]         ptr, gnt, sel, idx;
  logic                  found;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [TW-1:0]         timer;
  logic                  expired;

  logic [NUM_REQ-1:0]    req_ready_d, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_d, mem_data_in_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  rsp_err_d, mem_en_d, mem_wr_d, busy_d;
  logic [7:0]            err_cnt_d;

  assign expired = (timer == TW'(RD_TIMEOUT - 1));

  // Rotating search starting just after the last grant.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == sel) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = req_wr[sel] ? WRITE : READ;
      WRITE:   next_state = IDLE;
      READ:    next_state = WAIT;
      WAIT:    if (mem_vld_out || expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values are decoded one cycle early so the registers present them
  // in the state they belong to; mem_addr/mem_data_in double as the request latch.
  always_comb begin
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = '0;
    rsp_err_d     = 1'b0;
    mem_en_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;
    err_cnt_d     = err_cnt;
    busy_d        = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_d[sel] = 1'b1;
          mem_en_d         = 1'b1;
          mem_wr_d         = req_wr[sel];
          mem_addr_d       = sel_addr;
          mem_data_in_d    = req_wr[sel] ? sel_data : '0;
        end
      end
      WRITE: rsp_valid_d[gnt] = 1'b1;
      WAIT: begin
        if (mem_vld_out) begin
          rsp_valid_d[gnt] = 1'b1;
          rsp_data_d       = mem_data_out;
        end else if (expired) begin
          rsp_valid_d[gnt] = 1'b1;
          rsp_err_d        = 1'b1;
          err_cnt_d        = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      busy        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      mem_en      <= mem_en_d;
      mem_wr      <= mem_wr_d;
      mem_addr    <= mem_addr_d;
      mem_data_in <= mem_data_in_d;
      busy        <= busy_d;
      err_cnt     <= err_cnt_d;
    end
  end

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) begin
      ptr   <= PW'(NUM_REQ - 1);
      gnt   <= '0;
      timer <= '0;
    end else begin
      if (state == IDLE && found) begin
        ptr <= sel;
        gnt <= sel;
      end
      if (state == READ)
        timer <= '0;
      else if (state == WAIT && !mem_vld_out && !expired)
        timer <= timer + TW'(1);
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: requester agents, a latency-controlled memory
// and a transaction-level reference model (round-robin pick, cycle budget per transaction).
module tb_memory_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int RT = 16;

  logic              memory_clk, memory_rst;
  logic [NR-1:0]     req_valid, req_wr, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [DW-1:0]     rsp_data, mem_data_in, mem_data_out;
  logic              rsp_err, mem_en, mem_wr, mem_vld_out, busy;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        err_cnt;

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_TIMEOUT(RT)) dut (
    .memory_clk(memory_clk), .memory_rst(memory_rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_vld_out(mem_vld_out), .mem_data_out(mem_data_out),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial begin
    memory_clk = 1'b0;
    forever #5 memory_clk = ~memory_clk;
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // memory environment
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  int            cd = 0, rd_lat = 1;
  logic [AW-1:0] cd_addr;

  // reference model
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_ptr, free_at, rsp_at, rsp_g, err_model;
  bit            rsp_pend, rsp_exp_err, in_reset;
  logic [DW-1:0] rsp_exp_data, exp_din;
  logic [AW-1:0] exp_addr;

  // stimulus control and observations
  int            force_lat = -1, wr_pct = 50;
  int            credit [NR];
  int            glog [$];
  int            last_gcyc, last_rcyc;
  logic [DW-1:0] last_rdata;
  logic          last_rerr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int credits_left();
    int s = 0;
    for (int k = 0; k < NR; k++) s += credit[k];
    return s;
  endfunction

  task automatic reset_model();
    m_ptr = NR - 1; free_at = cyc; rsp_pend = 0; err_model = 0;
    exp_addr = '0; exp_din = '0; cd = 0; in_reset = 0;
  endtask

  task automatic score();
    int g, lat;
    logic wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NR-1:0] exp_ready, exp_rsp;
    if (in_reset) begin
      check("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_wr,
                                  mem_addr, mem_data_in, busy, err_cnt}), 64'(0));
      return;
    end
    exp_ready = '0;
    if (cyc - 1 >= free_at && req_valid != '0) begin
      g = rr_pick(m_ptr, req_valid);
      m_ptr = g;
      exp_ready = NR'(1) << g;
      wr = req_wr[g];
      a  = req_addr[g*AW +: AW];
      d  = req_data[g*DW +: DW];
      exp_addr = a;
      exp_din  = wr ? d : '0;
      check("mem_en_grant", 64'(mem_en), 64'(1));
      check("mem_wr", 64'(mem_wr), 64'(wr));
      rsp_pend = 1; rsp_g = g;
      if (wr) begin
        ref_mem[a] = d;
        rsp_at = cyc + 1; rsp_exp_data = '0; rsp_exp_err = 0;
      end else begin
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(1, 4));
        rd_lat = lat;
        if (lat >= 1 && lat <= RT) begin
          rsp_at = cyc + lat + 1; rsp_exp_data = ref_mem[a]; rsp_exp_err = 0;
        end else begin
          rsp_at = cyc + RT + 1; rsp_exp_data = '0; rsp_exp_err = 1;
        end
      end
      free_at = rsp_at;
    end else begin
      check("mem_en_idle", 64'(mem_en), 64'(0));
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (req_ready != '0) begin
      glog.push_back(idx_of(req_ready));
      last_gcyc = cyc;
    end
    check("mem_addr", 64'(mem_addr), 64'(exp_addr));
    check("mem_data_in", 64'(mem_data_in), 64'(exp_din));
    exp_rsp = (rsp_pend && cyc == rsp_at) ? (NR'(1) << rsp_g) : '0;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    if (exp_rsp != '0) begin
      check("rsp_data", 64'(rsp_data), 64'(rsp_exp_data));
      check("rsp_err", 64'(rsp_err), 64'(rsp_exp_err));
      if (rsp_exp_err && err_model < 255) err_model++;
      rsp_pend = 0;
    end
    if (rsp_valid != '0) begin
      last_rcyc = cyc; last_rdata = rsp_data; last_rerr = rsp_err;
    end
    check("err_cnt", 64'(err_cnt), 64'(err_model));
    check("busy", 64'(busy), 64'(cyc < free_at));
  endtask

  task automatic mem_step();
    mem_vld_out  = 1'b0;
    mem_data_out = DW'($urandom);
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_vld_out  = 1'b1;
        mem_data_out = env_mem[cd_addr];
      end
    end
    if (memory_rst && mem_en) begin
      if (mem_wr) env_mem[mem_addr] = mem_data_in;
      else begin
        cd_addr = mem_addr;
        cd      = rd_lat;
      end
    end
  endtask

  task automatic gen(input int i);
    req_valid[i] = 1'b1;
    req_wr[i]    = (int'($urandom_range(0, 99)) < wr_pct);
    req_addr[i*AW +: AW] = AW'($urandom);
    req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && credit[i] > 0) begin
        credit[i]--;
        gen(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge memory_clk);
    #1;
    cyc++;
    score();
    mem_step();
    drive();
  endtask

  task automatic drain();
    int budget = 4000;
    while (budget > 0 && (req_valid != '0 || credits_left() > 0 || cyc < free_at)) begin
      tick();
      budget--;
    end
    check("drain_budget", 64'(budget > 0), 64'(1));
  endtask

  initial begin
    int w;
    req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    mem_vld_out = 1'b0; mem_data_out = '0;
    for (int k = 0; k < NR; k++) credit[k] = 0;
    for (int k = 0; k < (1 << AW); k++) begin env_mem[k] = '0; ref_mem[k] = '0; end
    in_reset = 1; memory_rst = 1'b0;
    repeat (3) tick();
    memory_rst = 1'b1;
    reset_model();
    repeat (20) tick();

    // single write then read-back
    post(0, 1'b1, 4'h3, 8'hA5);
    drain();
    check("wr_rsp_err", 64'(last_rerr), 64'(0));
    force_lat = 2;
    post(0, 1'b0, 4'h3, 8'h00);
    drain();
    check("rd_data_a5", 64'(last_rdata), 64'(8'hA5));
    force_lat = -1;

    // fairness: req3 served last, then everyone streams writes
    post(3, 1'b1, 4'h0, 8'h11);
    drain();
    glog.delete();
    wr_pct = 100;
    for (int k = 0; k < NR; k++) credit[k] = 3;
    drain();
    check("fair_len", 64'(glog.size()), 64'(12));
    for (int k = 0; k < glog.size(); k++) check($sformatf("fair_order%0d", k), 64'(glog[k]), 64'(k % NR));

    // rotation after req2
    glog.delete();
    post(2, 1'b1, 4'h5, 8'h22);
    drain();
    post(1, 1'b1, 4'h6, 8'h33);
    post(3, 1'b1, 4'h7, 8'h44);
    drain();
    check("rot_len", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) begin
      check("rot0", 64'(glog[0]), 64'(2));
      check("rot1", 64'(glog[1]), 64'(3));
      check("rot2", 64'(glog[2]), 64'(1));
    end

    // timeout with a late valid, then valid on the final timer cycle
    check("err_before", 64'(err_cnt), 64'(0));
    force_lat = RT + 1;
    post(1, 1'b0, 4'h7, 8'h00);
    drain();
    check("to_err", 64'(last_rerr), 64'(1));
    check("to_data", 64'(last_rdata), 64'(0));
    check("to_delay", 64'(last_rcyc - last_gcyc), 64'(RT + 1));
    check("err_after", 64'(err_cnt), 64'(1));
    repeat (6) tick();
    force_lat = RT;
    post(2, 1'b0, 4'h3, 8'h00);
    drain();
    check("edge_err", 64'(last_rerr), 64'(0));
    check("edge_data", 64'(last_rdata), 64'(ref_mem[3]));
    check("edge_delay", 64'(last_rcyc - last_gcyc), 64'(RT + 1));

    // reset while waiting on a read
    force_lat = 0;
    post(2, 1'b0, 4'h9, 8'h00);
    w = 0;
    while (!req_ready[2] && w < 20) begin tick(); w++; end
    check("mr_grant", 64'(req_ready[2]), 64'(1));
    repeat (3) tick();
    memory_rst = 1'b0;
    #1;
    check("async_clear", 64'({busy, mem_en, rsp_valid, req_ready, err_cnt}), 64'(0));
    in_reset = 1; cd = 0;
    repeat (2) tick();
    memory_rst = 1'b1;
    reset_model();
    force_lat = -1;
    glog.delete();
    post(3, 1'b1, 4'h1, 8'h55);
    post(0, 1'b1, 4'h2, 8'h66);
    drain();
    check("post_rst_len", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) begin
      check("post_rst0", 64'(glog[0]), 64'(0));
      check("post_rst1", 64'(glog[1]), 64'(3));
    end

    // randomized mixed traffic
    wr_pct = 50;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NR; k++) credit[k] = int'($urandom_range(0, 15));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
